// File: rtl/avalon_mem_bridge_pkg.sv
// Shared types and helpers for the CPU-to-Avalon memory bridge: FSM states,
// byte-lane swap functions and the default timeout sizing.
package avalon_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int DEFAULT_CNT_W          = 11;

  // Avalon lanes are little-endian, the CPU is big-endian: reverse byte order.
  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [3:0] swap4(input logic [3:0] be);
    return {be[0], be[1], be[2], be[3]};
  endfunction

endpackage

// File: rtl/avalon_wait_timer.sv
// Counts stalled bus cycles; expired is high once TIMEOUT_CYCLES-1 stalled
// cycles have been seen since the last clear.
module avalon_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // Saturates at LAST so a lingering enable can never wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_mem_bridge.sv
// Bus-master bridge from the CPU control unit to Avalon-MM: one word request per
// handshake, endian swap, stall timeout. Optional posted writes under
// `AVALON_MEM_BRIDGE_POSTED_WRITE_EN.
module avalon_mem_bridge
  import avalon_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteen,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic accept;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the CPU holds req_* stable while req_valid is high and req_ready is low.
  assign accept   = req_valid && req_ready;
  assign timer_en = (state_q == BUS) && waitrequest;

`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_wdata_q, buf_wdata_d;
  logic [3:0]  buf_be_q, buf_be_d;
  logic        cur_wr_q, cur_wr_d;
  logic        post_rsp_q, post_rsp_d;
  logic        err_sticky_q, err_sticky_d;

  // A second write may be parked while a posted write is on the bus.
  assign req_ready = ((state_q == IDLE) && !buf_valid_q) ||
                     ((state_q == BUS) && write_q && req_write && !buf_valid_q);
  assign rsp_valid = ((state_q == RESP) && !cur_wr_q) || post_rsp_q;
  assign rsp_err   = rsp_err_q | err_sticky_q;
`else
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
`endif

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    timer_clear  = 1'b0;
`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    buf_be_d     = buf_be_q;
    cur_wr_d     = cur_wr_q;
    post_rsp_d   = accept && req_write;
    err_sticky_d = err_sticky_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
        if (buf_valid_q) begin
          state_d      = BUS;
          address_d    = buf_addr_q;
          read_d       = 1'b0;
          write_d      = 1'b1;
          writedata_d  = buf_wdata_q;
          byteenable_d = buf_be_q;
          rsp_err_d    = 1'b0;
          timer_clear  = 1'b1;
          buf_valid_d  = 1'b0;
          cur_wr_d     = 1'b1;
        end else
`endif
        if (accept) begin
          state_d      = BUS;
          address_d    = req_addr & ADDR_MASK;
          read_d       = !req_write;
          write_d      = req_write;
          writedata_d  = swap32(req_wdata);
          byteenable_d = swap4(req_byteen);
          rsp_err_d    = 1'b0;
          timer_clear  = 1'b1;
`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
          cur_wr_d     = req_write;
`endif
        end
      end
      BUS: begin
`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
        if (accept) begin
          buf_valid_d = 1'b1;
          buf_addr_d  = req_addr & ADDR_MASK;
          buf_wdata_d = swap32(req_wdata);
          buf_be_d    = swap4(req_byteen);
        end
        if (write_q && waitrequest && timer_expired) begin
          err_sticky_d = 1'b1;
        end
`endif
        // A released stall wins over a timeout landing on the same edge.
        if (!waitrequest || timer_expired) begin
          state_d   = RESP;
          read_d    = 1'b0;
          write_d   = 1'b0;
          rsp_err_d = waitrequest;
          if (read_q && !waitrequest) begin
            rsp_rdata_d = swap32(readdata);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      buf_be_q     <= '0;
      cur_wr_q     <= 1'b0;
      post_rsp_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      buf_be_q     <= buf_be_d;
      cur_wr_q     <= cur_wr_d;
      post_rsp_q   <= post_rsp_d;
      err_sticky_q <= err_sticky_d;
    end
  end
`endif

  avalon_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_avalon_mem_bridge.sv
// Bench for avalon_mem_bridge: directed cases plus random requests checked
// against a transaction-level model of latency, swapping and timeout.
module tb_avalon_mem_bridge;
  import avalon_mem_bridge_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byteen;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;
  logic        model_sticky;

  always #5 clk = ~clk;

  avalon_mem_bridge #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_byteen (req_byteen),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .address    (address),
    .read       (read),
    .write      (write),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata),
    .dbg_state  (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 4; i++) y[8*i +: 8] = x[8*(3-i) +: 8];
    return y;
  endfunction

  function automatic logic [3:0] be_rev(input logic [3:0] b);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = b[3-i];
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; bus stalls w cycles then releases. Entered and left at edge+1 in IDLE.
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int w, input logic [31:0] rd);
    bit tmo;
    bit in_bus;
    int bus_cycles;
    int rsp_k;
    tmo        = (w >= T);
    bus_cycles = tmo ? T : w + 1;
    rsp_k      = bus_cycles + 1;
`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
    if (wr) rsp_k = 1;
`endif
    if (!wr && !tmo) exp_q.push_back(bswap(rd));
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_byteen = be;
    waitrequest = 1'b1;
    #1;
    check_eq("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    req_addr = $urandom(); req_wdata = $urandom(); req_byteen = 4'($urandom());
    for (int k = 1; k <= bus_cycles + 2; k++) begin
      waitrequest = (k <= w);
      readdata    = (k == w + 1) ? rd : $urandom();
      if (k == bus_cycles + 1 && !wr && !tmo && exp_q.size() > 0) model_rdata = exp_q.pop_front();
      #1;
      in_bus = (k <= bus_cycles);
      check_eq("read", read, in_bus && !wr);
      check_eq("write", write, in_bus && wr);
      check_eq("rsp_valid", rsp_valid, k == rsp_k);
      check_eq("rsp_rdata", rsp_rdata, model_rdata);
      check_eq("req_ready", req_ready, k == bus_cycles + 2);
      if (in_bus) begin
        check_eq("address", address, a & 32'hFFFF_FFFC);
        check_eq("writedata", writedata, bswap(wd));
        check_eq("byteenable", byteenable, be_rev(be));
        check_eq("state_bus", dbg_state, BUS);
      end
      if (k == rsp_k) check_eq("rsp_err", rsp_err, (tmo && rsp_k != 1) || model_sticky);
      tick();
    end
`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
    if (wr && tmo) model_sticky = 1'b1;
`endif
  endtask

`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
  // Two posted writes then a read; every bus access stalls two cycles.
  task automatic posted_seq();
    int stall, wr_done, rsp_cnt;
    bit read_early, rd_acc, rd_now;
    logic [31:0] rd;
    rd = $urandom();
    readdata = rd;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = $urandom();
    req_byteen = 4'hF; waitrequest = 1'b1;
    #1;
    check_eq("pw_ready_w1", req_ready, 1'b1);
    tick();
    req_addr = 32'h44; req_wdata = $urandom(); waitrequest = 1'b1;
    #1;
    check_eq("pw_rsp_w1", rsp_valid, 1'b1);
    check_eq("pw_err_w1", rsp_err, model_sticky);
    check_eq("pw_ready_w2", req_ready, 1'b1);
    tick();
    req_write = 1'b0; req_addr = 32'h48; waitrequest = 1'b1;
    #1;
    check_eq("pw_rsp_w2", rsp_valid, 1'b1);
    check_eq("pw_ready_rd_blocked", req_ready, 1'b0);
    stall = 2; wr_done = 0; rsp_cnt = 0; read_early = 0; rd_acc = 0;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (read || write) begin
        if (stall < 2) begin
          waitrequest = 1'b1; stall++;
        end else begin
          waitrequest = 1'b0; stall = 0;
          if (write) wr_done++;
        end
      end else begin
        waitrequest = 1'b0;
      end
      #1;
      if (read && wr_done < 2) read_early = 1'b1;
      if (rsp_valid) begin
        rsp_cnt++;
        model_rdata = bswap(rd);
        check_eq("pw_rd_data", rsp_rdata, model_rdata);
        check_eq("pw_rd_err", rsp_err, model_sticky);
      end
      rd_now = req_valid && req_ready;
      tick();
      if (rd_now) begin
        req_valid = 1'b0; rd_acc = 1'b1;
      end
    end
    check_eq("pw_rd_accepted", rd_acc, 1'b1);
    check_eq("pw_writes_done", wr_done, 2);
    check_eq("pw_read_order", read_early, 1'b0);
    check_eq("pw_rsp_count", rsp_cnt, 1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_byteen = '0; waitrequest = 1'b0; readdata = '0;
    model_rdata = '0; model_sticky = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_read", read, 1'b0);
    check_eq("rst_write", write, 1'b0);
    check_eq("rst_address", address, 32'h0);
    check_eq("rst_writedata", writedata, 32'h0);
    check_eq("rst_byteenable", byteenable, 4'h0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_state", dbg_state, IDLE);
    tick();
    @(negedge clk) reset = 1'b1;
    tick();
    check_eq("ready_after_reset", req_ready, 1'b1);

    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'h1122_3344);
    check_eq("t1_rdata", rsp_rdata, 32'h4433_2211);
    do_txn(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0011, 3, 32'h0);
    do_txn(1'b0, 32'h0000_0013, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 100, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'h0000_0104, 32'h0, 4'hF, T - 1, 32'h0102_0304);

    // reset in the middle of a stalled read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80; req_byteen = 4'hF; waitrequest = 1'b1;
    #1;
    check_eq("rst_mid_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #1;
    check_eq("rst_mid_read_before", read, 1'b1);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_mid_read_async", read, 1'b0);
    check_eq("rst_mid_write_async", write, 1'b0);
    check_eq("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
    model_rdata = '0; model_sticky = 1'b0; exp_q.delete();
    tick();
    @(negedge clk) begin reset = 1'b1; waitrequest = 1'b0; end
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_mid_no_rsp", rsp_valid, 1'b0);
      check_eq("rst_mid_idle_read", read, 1'b0);
      tick();
    end
    do_txn(1'b0, 32'h0000_0200, 32'h0, 4'hF, 2, 32'h5566_7788);

`ifdef AVALON_MEM_BRIDGE_POSTED_WRITE_EN
    posted_seq();
`endif

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom()),
             $urandom_range(0, T + 3), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
